tbre_scan_ctrl: RTL and testbench
=================================

TBRE_SCAN_CTRL -- requirements
Module: tbre_scan_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, meaning: maximum wait cycles from grant to mem_rvalid_i; range 1..65535.
REQ-002 clk_i  input  1  single clock, all state on rising edge.
REQ-003 rstn_i  input  1  reset, asynchronous, active-low.
REQ-004 mmreg_corein_i  input  128  configuration: [31:0] start address, [63:32] end address, [64] go pulse, [127:65] ignored.
REQ-005 mmreg_coreout_o  output  64  status: [0] busy, [1] err, [15:2] zero, [31:16] non-zero word count, [63:32] current address.
REQ-006 mem_req_o  output  1  read request.
REQ-007 mem_addr_o  output  32  read word address, bits [1:0] always 0.
REQ-008 mem_gnt_i  input  1  request accepted this cycle.
REQ-009 mem_rvalid_i  input  1  read response valid.
REQ-010 mem_rdata_i  input  32  read response data.
REQ-011 mem_err_i  input  1  response error, qualified by mem_rvalid_i.

Function
REQ-012 The block SHALL implement four states: IDLE, REQ, WAIT, FIN.
REQ-013 In IDLE, go=1 SHALL latch start[31:2], end[31:2] (bits [1:0] forced to 0), clear err and the count, and load the current address with start.
REQ-014 If the latched start > latched end, the block SHALL set err=1 and move IDLE->FIN, issuing no request; otherwise it SHALL move IDLE->REQ.
REQ-015 go SHALL be ignored in every state other than IDLE, with no effect on any register.
REQ-016 In REQ, mem_req_o SHALL be 1 with mem_addr_o = current address, held stable until mem_gnt_i=1; a grant SHALL move REQ->WAIT and clear the wait timer.
REQ-017 mem_req_o SHALL be 0 in IDLE, WAIT, FIN; at most one read SHALL be outstanding.
REQ-018 In WAIT, the timer SHALL increment each cycle without rvalid; when timer == TIMEOUT_CYCLES with no rvalid, err SHALL be set and the state SHALL move to FIN.
REQ-019 In WAIT, rvalid with mem_err_i=1 SHALL set err=1 and move to FIN, with the count unchanged.
REQ-020 In WAIT, rvalid with mem_err_i=0 SHALL increment the count when rdata != 0; the count is 16 bits and saturates at 16'hFFFF.
REQ-021 After a good response, current address == end SHALL move to FIN; otherwise the current address SHALL advance by 4 and the state SHALL move to REQ.
REQ-022 End = 32'hFFFF_FFFC SHALL terminate at end with no address wrap.
REQ-023 The block SHALL ignore mem_rvalid_i and mem_gnt_i outside WAIT and REQ respectively.
REQ-024 busy SHALL be a registered output equal to (state != IDLE): it rises the cycle after an accepted go and falls the cycle after FIN.
REQ-025 FIN SHALL last exactly one cycle, then move to IDLE, so every accepted go produces exactly one busy 1->0 edge, including the error cases.
REQ-026 err, count and current address SHALL hold their values in IDLE until the next accepted go.
REQ-027 Latency SHALL be: go to first mem_req_o = 2 cycles; single-word scan with gnt and rvalid each one cycle after request = busy high for 4 cycles.

Reset
REQ-028 rstn_i low SHALL force IDLE and clear mem_req_o, mem_addr_o, busy, err, count, current address and timer to 0, including mid-scan.
REQ-029 After reset release, outstanding responses from before reset SHALL be ignored, since the block is in IDLE.

Verification
REQ-030 start=0x100, end=0x10C, memory words {0, 5, 0, 7}, gnt and rvalid immediate -> addresses 0x100..0x10C in order, count=2, err=0, one busy falling edge.
REQ-031 start=0x20, end=0x10 -> no mem_req_o, err=1, busy high for exactly 1 cycle.
REQ-032 start=end=0x40, rvalid withheld, TIMEOUT_CYCLES=4 -> err=1 after 4 wait cycles, then IDLE, count=0.
REQ-033 Grant delayed 3 cycles, plus a go pulse during the scan -> mem_addr_o stable while ungranted; the extra go has no effect.
REQ-034 rvalid with mem_err_i=1 on the 2nd word of 4 -> scan stops, err=1, current address = start+4.
REQ-035 rstn_i asserted in WAIT, then a stray rvalid after release -> all status 0, no state change.

Source files
------------

// File: rtl/tbre_scan_ctrl_if.sv
// Read-request bus between the scan controller (master) and a word memory (slave).
// One outstanding read: request/grant handshake, then a single valid response.
interface tbre_scan_ctrl_if;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;

  modport master (
    output mem_req_o, mem_addr_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
  );
endinterface

// File: rtl/tbre_scan_ctrl.sv
// Word-range scanner: reads every word from start to end, counts the non-zero
// words and reports busy/err/count/current address on a status register.
module tbre_scan_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [127:0]     mmreg_corein_i,
  output logic [63:0]      mmreg_coreout_o,
  tbre_scan_ctrl_if.master mem
);
  localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_FIN} state_t;

  state_t      state, state_nxt;
  logic        go_p0;
  logic [29:0] start_p0, end_p0;
  logic [29:0] end_lat, cur_addr;
  logic        err, busy;
  logic [15:0] cnt, timer;
  logic        unused_cfg;

  assign unused_cfg = ^{mmreg_corein_i[127:65], mmreg_corein_i[33:32], mmreg_corein_i[1:0]};

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Stage p0: configuration capture, only while idle so a go during a scan is dropped
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) go_p0 <= 1'b0;
    else         go_p0 <= mmreg_corein_i[64] && (state == ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (state == ST_IDLE && mmreg_corein_i[64]) begin
      start_p0 <= mmreg_corein_i[31:2];
      end_p0   <= mmreg_corein_i[63:34];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (go_p0) state_nxt = (start_p0 > end_p0) ? ST_FIN : ST_REQ;
      ST_REQ:  if (mem.mem_gnt_i) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (mem.mem_rvalid_i) begin
          if (mem.mem_err_i || cur_addr == end_lat) state_nxt = ST_FIN;
          else                                       state_nxt = ST_REQ;
        end else if (timer == TMO) begin
          state_nxt = ST_FIN;
        end
      end
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Stage p1: scan state and status registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      err      <= 1'b0;
      cnt      <= '0;
      cur_addr <= '0;
      end_lat  <= '0;
      timer    <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (go_p0) begin
            end_lat  <= end_p0;
            cur_addr <= start_p0;
            err      <= (start_p0 > end_p0);
            cnt      <= '0;
          end
        end
        ST_REQ: begin
          if (mem.mem_gnt_i) timer <= '0;
        end
        ST_WAIT: begin
          if (mem.mem_rvalid_i) begin
            if (mem.mem_err_i) begin
              err <= 1'b1;
            end else begin
              if (mem.mem_rdata_i != 32'd0) cnt <= sat_inc(cnt);
              // Stopping at end before incrementing keeps 0xFFFF_FFFC from wrapping
              if (cur_addr != end_lat) cur_addr <= cur_addr + 30'd1;
            end
          end else if (timer == TMO) begin
            err <= 1'b1;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem.mem_req_o   = (state == ST_REQ);
  assign mem.mem_addr_o  = {cur_addr, 2'b00};
  assign mmreg_coreout_o = {cur_addr, 2'b00, cnt, 14'd0, err, busy};
endmodule

// File: tb/tb_tbre_scan_ctrl.sv
// Directed bench for tbre_scan_ctrl: table of scan configurations with hand-computed
// results, plus sequences for grant delay with a stray go, and reset mid-scan.
module tb_tbre_scan_ctrl;
  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [127:0] corein = '0;
  logic [63:0]  coreout;

  tbre_scan_ctrl_if bus();

  tbre_scan_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .mmreg_corein_i (corein),
    .mmreg_coreout_o(coreout),
    .mem            (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] start;
    logic [31:0] stop;
    int          dly;
    logic [31:0] err_addr;
    bit          no_rv;
    logic        exp_err;
    logic [15:0] exp_cnt;
    logic [31:0] exp_addr;
    int          exp_busy;
    int          exp_words;
  } vec_t;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_words [16];
  int          gnt_dly  = 0;
  int          age      = 0;
  bit          no_rv    = 1'b0;
  logic [31:0] err_addr = 32'h1;
  logic        rv_q = 1'b0, er_q = 1'b0;
  logic [31:0] rd_q = '0;
  logic        stray_rv = 1'b0, stray_err = 1'b0;
  logic [31:0] stray_data = '0;
  logic [31:0] gaddr [$];
  int          viol = 0;
  bit          prev_pend = 1'b0;
  logic [31:0] prev_addr = '0;

  assign bus.mem_gnt_i    = bus.mem_req_o && (age >= gnt_dly);
  assign bus.mem_rvalid_i = rv_q | stray_rv;
  assign bus.mem_rdata_i  = stray_rv ? stray_data : rd_q;
  assign bus.mem_err_i    = stray_rv ? stray_err  : er_q;

  // Memory responder: grant after gnt_dly waiting cycles, answer the cycle after grant
  always @(posedge clk) begin
    if (bus.mem_req_o && !bus.mem_gnt_i) age <= age + 1;
    else                                 age <= 0;
    rv_q <= bus.mem_req_o && bus.mem_gnt_i && !no_rv;
    rd_q <= mem_words[bus.mem_addr_o[5:2]];
    er_q <= (bus.mem_addr_o == err_addr);
    if (bus.mem_req_o && bus.mem_gnt_i) gaddr.push_back(bus.mem_addr_o);
    if (prev_pend && bus.mem_req_o && bus.mem_addr_o != prev_addr) viol <= viol + 1;
    prev_pend <= bus.mem_req_o && !bus.mem_gnt_i;
    prev_addr <= bus.mem_addr_o;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_scan(input vec_t v, input bit extra_go, input string tag);
    int  n = 0, busy_cnt = 0, falls = 0, lat = -1;
    bit  prev_b = 1'b0, done = 1'b0, ok;
    logic [31:0] s_al;
    gnt_dly  = v.dly;
    no_rv    = v.no_rv;
    err_addr = v.err_addr;
    gaddr.delete();
    @(negedge clk);
    corein          = '0;
    corein[31:0]    = v.start;
    corein[63:32]   = v.stop;
    corein[64]      = 1'b1;
    corein[127:96]  = 32'hA5A5_5A5A;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
      if (n == 1) corein[64] = 1'b0;
      if (extra_go && n == 4) begin
        corein[31:0]  = 32'h0;
        corein[63:32] = 32'h1000;
        corein[64]    = 1'b1;
      end
      if (extra_go && n == 5) corein[64] = 1'b0;
      if (bus.mem_req_o && lat < 0) lat = n;
      if (coreout[0]) busy_cnt++;
      if (prev_b && !coreout[0]) begin
        falls++;
        done = 1'b1;
      end
      prev_b = coreout[0];
    end
    chk({tag, " done"}, 64'(done), 64'd1);
    chk({tag, " err"}, 64'(coreout[1]), 64'(v.exp_err));
    chk({tag, " count"}, 64'(coreout[31:16]), 64'(v.exp_cnt));
    chk({tag, " addr"}, 64'(coreout[63:32]), 64'(v.exp_addr));
    chk({tag, " zero_field"}, 64'(coreout[15:2]), 64'd0);
    chk({tag, " busy_cycles"}, 64'(busy_cnt), 64'(v.exp_busy));
    chk({tag, " busy_falls"}, 64'(falls), 64'd1);
    chk({tag, " words"}, 64'(gaddr.size()), 64'(v.exp_words));
    chk({tag, " req_latency"}, 64'(lat), (v.exp_words > 0) ? 64'd2 : 64'hFFFF_FFFF_FFFF_FFFF);
    s_al = {v.start[31:2], 2'b00};
    ok = 1'b1;
    for (int i = 0; i < gaddr.size(); i++)
      if (gaddr[i] != s_al + 32'(4 * i)) ok = 1'b0;
    chk({tag, " addr_order"}, 64'(ok), 64'd1);
    repeat (3) @(negedge clk);
    chk({tag, " hold"}, coreout, {v.exp_addr, v.exp_cnt, 14'd0, v.exp_err, 1'b0});
  endtask

  vec_t vecs [7];
  vec_t gv;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    mem_words = '{32'h0, 32'h5, 32'h0, 32'h7, 32'h1, 32'h0, 32'h0, 32'h9,
                  32'h0, 32'h0, 32'h0, 32'h0, 32'h3, 32'h3, 32'h0, 32'hFFFF_FFFF};
    //           start          stop           dly err_addr   norv err cnt   addr           busy words
    vecs[0] = '{32'h100,       32'h10C,       0, 32'h1,     0, 0, 16'd2, 32'h10C,       9, 4};
    vecs[1] = '{32'h20,        32'h10,        0, 32'h1,     0, 1, 16'd0, 32'h20,        1, 0};
    vecs[2] = '{32'h44,        32'h44,        1, 32'h1,     0, 0, 16'd1, 32'h44,        4, 1};
    vecs[3] = '{32'h110,       32'h11C,       0, 32'h114,   0, 1, 16'd1, 32'h114,       5, 2};
    vecs[4] = '{32'h103,       32'h107,       0, 32'h1,     0, 0, 16'd1, 32'h104,       5, 2};
    vecs[5] = '{32'hFFFF_FFF8, 32'hFFFF_FFFF, 0, 32'h1,     0, 0, 16'd1, 32'hFFFF_FFFC, 5, 2};
    vecs[6] = '{32'h40,        32'h40,        0, 32'h1,     1, 1, 16'd0, 32'h40,        7, 1};
    gv      = '{32'h130,       32'h134,       3, 32'h1,     0, 0, 16'd2, 32'h134,      11, 2};

    repeat (2) @(negedge clk);
    chk("reset status", coreout, 64'd0);
    chk("reset req", 64'(bus.mem_req_o), 64'd0);
    chk("reset addr", 64'(bus.mem_addr_o), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_reset status", coreout, 64'd0);

    for (int i = 0; i < 7; i++) run_scan(vecs[i], 1'b0, $sformatf("vec%0d", i));

    viol = 0;
    run_scan(gv, 1'b1, "gnt_delay");
    chk("gnt_delay addr_stable", 64'(viol), 64'd0);

    // Reset while waiting for a response that never comes, then stray responses
    gnt_dly  = 0;
    no_rv    = 1'b1;
    err_addr = 32'h1;
    @(negedge clk);
    corein        = '0;
    corein[31:0]  = 32'h100;
    corein[63:32] = 32'h10C;
    corein[64]    = 1'b1;
    @(negedge clk);
    corein[64] = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid busy", 64'(coreout[0]), 64'd1);
    rstn = 1'b0;
    #1;
    chk("mid reset status", coreout, 64'd0);
    chk("mid reset req", 64'(bus.mem_req_o), 64'd0);
    chk("mid reset addr", 64'(bus.mem_addr_o), 64'd0);
    repeat (2) @(negedge clk);
    rstn  = 1'b1;
    no_rv = 1'b0;
    @(negedge clk);
    stray_rv   = 1'b1;
    stray_data = 32'h7;
    stray_err  = 1'b0;
    @(negedge clk);
    stray_data = 32'h9;
    stray_err  = 1'b1;
    @(negedge clk);
    stray_rv = 1'b0;
    repeat (2) @(negedge clk);
    chk("stray status", coreout, 64'd0);
    chk("stray req", 64'(bus.mem_req_o), 64'd0);

    run_scan(vecs[0], 1'b0, "recover");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
